nonce_result_scanner: RTL and testbench
=======================================

// Module: nonce_result_scanner
// PURPOSE
//  Post-processing stage downstream of the bitcoin hash engine. After the engine writes its
//  NUM_NONCES H0 words to memory, this block reads them back from hash_base_addr and compares
//  each one against a 32-bit target. It keeps the minimum hash and its nonce index, then writes
//  a two-word result record to result_addr. Drives the same shared memory port style as the engine.
// PARAMETERS
//  NUM_NONCES  16  number of consecutive H0 words to scan (1..256); IDX_W=$clog2(NUM_NONCES) local
// PORTS
//  clk                input   1   single clock; also drives mem_clk
//  reset_n            input   1   asynchronous, active-low reset
//  start              input   1   begin scan; sampled only in IDLE
//  hash_base_addr     input   16  word address of nonce 0's H0 word; latched at start
//  result_addr        input   16  word address of the 2-word result record; latched at start
//  target             input   32  unsigned threshold; latched at start
//  done               output  1   high exactly while in IDLE
//  found              output  1   best_hash < target (unsigned) for the last completed scan
//  best_nonce         output  8   index of the minimum hash word (zero-extended)
//  best_hash          output  32  minimum H0 value seen
//  mem_clk            output  1   = clk
//  mem_we             output  1   registered write enable
//  memory_addr        output  16  registered word address
//  memory_write_data  output  32  registered write data
//  memory_read_data   input   32  read data; valid 2 edges after memory_addr is registered
// BEHAVIOUR
//  Reset values: state=IDLE, done=1, mem_we=0, memory_addr=0, memory_write_data=0, found=0,
//   best_nonce=0, best_hash=32'hFFFFFFFF, idx=0. Reset mid-scan aborts. mem_we falls
//   asynchronously with reset_n and no further writes occur.
//  FSM states: IDLE, PRIME, SCAN, WRITE0, WRITE1, FINISH. Edge numbering starts at edge0, where
//   start is sampled.
//  IDLE: on start=1, latch inputs, memory_addr<=hash_base_addr, idx<=0, best_hash<=FFFFFFFF,
//   best_nonce<=0, found<=0, then go to PRIME. start=0 holds IDLE. start is ignored in every
//   other state.
//  PRIME (edge1): memory_addr<=memory_addr+1; go to SCAN. No data is captured.
//  SCAN (edges 2..NUM_NONCES+1): capture memory_read_data as word idx.
//   - Strict unsigned compare: if word < best_hash, update best_hash and best_nonce<=idx. Ties
//     keep the lower index.
//   - memory_addr increments while fewer than NUM_NONCES addresses have been issued, then holds.
//   - After word NUM_NONCES-1: found<=(final best_hash < target), evaluated on the post-update
//     value; go to WRITE0.
//  WRITE0: mem_we<=1, memory_addr<=result_addr, memory_write_data<={found,23'b0,best_nonce}.
//  WRITE1: memory_addr<=result_addr+1, memory_write_data<=best_hash, mem_we stays 1.
//  FINISH: mem_we<=0; go to IDLE. done rises after edge NUM_NONCES+4 (edge20 for the default).
//  Address arithmetic is 16-bit and wraps modulo 2^16 (base 16'hFFFF reads FFFF, 0000, ...).
//  target=0 means found=0 always. target=FFFFFFFF means found=1 unless every word is FFFFFFFF.
//  found, best_nonce and best_hash hold stable in IDLE until the next accepted start.
//  mem_we is 1 for exactly 2 cycles per scan and never during PRIME or SCAN.
// TESTING
//  1 Words 16..1 at base 0x100 (word i = 16-i), target=5, result 0x200 -> best_nonce=15,
//    best_hash=1, found=1; mem[0x200]=32'h8000000F, mem[0x201]=1; done after edge20.
//  2 All words 32'hFFFFFFFF, target=32'hFFFFFFFF -> found=0, best_nonce=0, mem[0x200]=0,
//    mem[0x201]=FFFFFFFF.
//  3 Words 3,7,3,9..., target=4 -> tie resolved to best_nonce=0, best_hash=3, found=1.
//  4 target=0 with any data -> found=0, record word0 bit31=0, best values still reported.
//  5 hash_base_addr=16'hFFF8 -> reads wrap FFF8..0007; minimum placed at 0x0003 -> best_nonce=11.
//  6 start held high through the whole scan, then reset_n pulsed low at edge8 -> mem_we stays 0,
//    done=1 immediately, outputs at reset values; a new start rescans cleanly.

Source files
------------

// File: rtl/nonce_result_scanner.sv
// Reads back NUM_NONCES H0 words from shared memory, tracks the minimum hash and its
// nonce index, and writes a two-word result record {found,0,best_nonce} / best_hash.
module nonce_result_scanner #(
  parameter int NUM_NONCES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [15:0] hash_base_addr,
  input  logic [15:0] result_addr,
  input  logic [31:0] target,
  output logic        done,
  output logic        found,
  output logic [7:0]  best_nonce,
  output logic [31:0] best_hash,
  output logic        mem_clk,
  output logic        mem_we,
  output logic [15:0] memory_addr,
  output logic [31:0] memory_write_data,
  input  logic [31:0] memory_read_data
);

  localparam int IDX_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NONCES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SCAN,
    WRITE0,
    WRITE1,
    FINISH
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [15:0]      result_addr_q;
  logic [31:0]      target_q;

  logic             word_less;
  logic [31:0]      next_best;
  logic             more_addr;

  assign mem_clk = clk;

  // Two reads are already in flight when word idx arrives, so further addresses are
  // issued only while idx+2 is still below the word count.
  always_comb begin
    word_less = 1'b0;
    next_best = best_hash;
    more_addr = 1'b0;
    word_less = (memory_read_data < best_hash);
    next_best = word_less ? memory_read_data : best_hash;
    more_addr = ({1'b0, 8'(idx)} + 9'd2) < 9'(NUM_NONCES);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state             <= IDLE;
      done              <= 1'b1;
      mem_we            <= 1'b0;
      memory_addr       <= 16'h0000;
      memory_write_data <= 32'h0000_0000;
      found             <= 1'b0;
      best_nonce        <= 8'h00;
      best_hash         <= 32'hFFFF_FFFF;
      idx               <= '0;
      result_addr_q     <= 16'h0000;
      target_q          <= 32'h0000_0000;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            result_addr_q <= result_addr;
            target_q      <= target;
            memory_addr   <= hash_base_addr;
            idx           <= '0;
            best_hash     <= 32'hFFFF_FFFF;
            best_nonce    <= 8'h00;
            found         <= 1'b0;
            done          <= 1'b0;
            state         <= PRIME;
          end
        end
        PRIME: begin
          memory_addr <= memory_addr + 16'd1;
          state       <= SCAN;
        end
        SCAN: begin
          if (word_less) begin
            best_hash  <= memory_read_data;
            best_nonce <= 8'(idx);
          end
          if (more_addr) begin
            memory_addr <= memory_addr + 16'd1;
          end
          if (idx == LAST_IDX) begin
            found <= (next_best < target_q);
            state <= WRITE0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        WRITE0: begin
          mem_we            <= 1'b1;
          memory_addr       <= result_addr_q;
          memory_write_data <= {found, 23'b0, best_nonce};
          state             <= WRITE1;
        end
        WRITE1: begin
          memory_addr       <= result_addr_q + 16'd1;
          memory_write_data <= best_hash;
          state             <= FINISH;
        end
        FINISH: begin
          mem_we <= 1'b0;
          done   <= 1'b1;
          state  <= IDLE;
        end
        default: begin
          state  <= IDLE;
          mem_we <= 1'b0;
          done   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_result_scanner.sv
// Directed bench for nonce_result_scanner with a one-cycle-latency synchronous memory model.
module tb_nonce_result_scanner;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [15:0] hash_base_addr;
  logic [15:0] result_addr;
  logic [31:0] target;
  logic        done;
  logic        found;
  logic [7:0]  best_nonce;
  logic [31:0] best_hash;
  logic        mem_clk;
  logic        mem_we;
  logic [15:0] memory_addr;
  logic [31:0] memory_write_data;
  logic [31:0] memory_read_data;

  logic [31:0] mem [0:65535];
  logic        load_en;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  int          we_count;
  int          compared;
  int          mismatched;

  nonce_result_scanner #(.NUM_NONCES(16)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .hash_base_addr    (hash_base_addr),
    .result_addr       (result_addr),
    .target            (target),
    .done              (done),
    .found             (found),
    .best_nonce        (best_nonce),
    .best_hash         (best_hash),
    .mem_clk           (mem_clk),
    .mem_we            (mem_we),
    .memory_addr       (memory_addr),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: read data appears one edge after the address edge; the bench preloads through load_en.
  always @(posedge mem_clk) begin
    memory_read_data <= mem[memory_addr];
    if (load_en) mem[load_addr] <= load_data;
    else if (mem_we) mem[memory_addr] <= memory_write_data;
    if (mem_we) we_count <= we_count + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic loadWord(input logic [15:0] a, input logic [31:0] d);
    load_addr = a;
    load_data = d;
    load_en   = 1'b1;
    @(posedge clk);
    #1 load_en = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [15:0] res, input logic exp_found,
                             input logic [7:0] exp_nonce, input logic [31:0] exp_hash);
    checkOutput({tag, ".found"}, {31'b0, found}, {31'b0, exp_found});
    checkOutput({tag, ".best_nonce"}, {24'b0, best_nonce}, {24'b0, exp_nonce});
    checkOutput({tag, ".best_hash"}, best_hash, exp_hash);
    checkOutput({tag, ".rec0"}, mem[res], {exp_found, 23'b0, exp_nonce});
    checkOutput({tag, ".rec1"}, mem[16'(res + 16'd1)], exp_hash);
  endtask

  task automatic applyStimulus(input string tag, input logic [15:0] base, input logic [15:0] res,
                               input logic [31:0] tgt, input logic exp_found,
                               input logic [7:0] exp_nonce, input logic [31:0] exp_hash);
    int we_before;
    int guard;
    loadWord(res, 32'hDEAD_BEEF);
    loadWord(16'(res + 16'd1), 32'hDEAD_BEEF);
    hash_base_addr = base;
    result_addr    = res;
    target         = tgt;
    start          = 1'b1;
    we_before      = we_count;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1 checkOutput({tag, ".done_edge19"}, {31'b0, done}, 32'd0);
    @(posedge clk);
    #1 checkOutput({tag, ".done_edge20"}, {31'b0, done}, 32'd1);
    guard = 0;
    while (!done && guard < 50) begin
      @(posedge clk);
      #1 guard++;
    end
    checkOutput({tag, ".we_cycles"}, 32'(we_count - we_before), 32'd2);
    checkResult(tag, res, exp_found, exp_nonce, exp_hash);
  endtask

  initial begin
    compared       = 0;
    mismatched     = 0;
    we_count       = 0;
    load_en        = 1'b0;
    load_addr      = 16'h0;
    load_data      = 32'h0;
    start          = 1'b0;
    hash_base_addr = 16'h0;
    result_addr    = 16'h0;
    target         = 32'h0;
    reset_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.done", {31'b0, done}, 32'd1);
    checkOutput("reset.mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("reset.addr", {16'b0, memory_addr}, 32'd0);
    checkOutput("reset.wdata", memory_write_data, 32'd0);
    checkOutput("reset.found", {31'b0, found}, 32'd0);
    checkOutput("reset.nonce", {24'b0, best_nonce}, 32'd0);
    checkOutput("reset.hash", best_hash, 32'hFFFF_FFFF);
    reset_n = 1'b1;

    // Descending words: minimum 1 at index 15
    for (int i = 0; i < 16; i++) loadWord(16'(16'h0100 + i), 32'(16 - i));
    applyStimulus("t1", 16'h0100, 16'h0200, 32'd5, 1'b1, 8'd15, 32'd1);
    checkOutput("t1.rec0_const", mem[16'h0200], 32'h8000_000F);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("t1.hold_nonce", {24'b0, best_nonce}, 32'd15);
    checkOutput("t1.hold_hash", best_hash, 32'd1);
    checkOutput("t1.hold_found", {31'b0, found}, 32'd1);
    checkOutput("t1.hold_we", {31'b0, mem_we}, 32'd0);

    // All-ones data never beats the initial best; strict compare against all-ones target
    for (int i = 0; i < 16; i++) loadWord(16'(16'h0500 + i), 32'hFFFF_FFFF);
    applyStimulus("t2", 16'h0500, 16'h0210, 32'hFFFF_FFFF, 1'b0, 8'd0, 32'hFFFF_FFFF);

    // Tie at value 3 keeps index 0
    for (int i = 0; i < 16; i++) loadWord(16'(16'h0600 + i), 32'(10 + i));
    loadWord(16'h0600, 32'd3);
    loadWord(16'h0601, 32'd7);
    loadWord(16'h0602, 32'd3);
    loadWord(16'h0603, 32'd9);
    applyStimulus("t3", 16'h0600, 16'h0220, 32'd4, 1'b1, 8'd0, 32'd3);

    // target zero: never found, best still reported
    for (int i = 0; i < 16; i++) loadWord(16'(16'h0700 + i), 32'(100 + i));
    loadWord(16'h0706, 32'd7);
    applyStimulus("t4", 16'h0700, 16'h0230, 32'd0, 1'b0, 8'd6, 32'd7);

    // Address wrap: FFF8..0007, minimum at 0x0003 is index 11
    for (int i = 0; i < 16; i++) loadWord(16'(16'hFFF8 + i), 32'd1000);
    loadWord(16'h0003, 32'd20);
    applyStimulus("t5", 16'hFFF8, 16'h0300, 32'hFFFF_FFFF, 1'b1, 8'd11, 32'd20);

    // Reset mid-scan with start held high
    loadWord(16'h0400, 32'h1234_5678);
    loadWord(16'h0401, 32'h1234_5678);
    hash_base_addr = 16'h0100;
    result_addr    = 16'h0400;
    target         = 32'd5;
    start          = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("t6.done", {31'b0, done}, 32'd1);
    checkOutput("t6.mem_we", {31'b0, mem_we}, 32'd0);
    checkOutput("t6.addr", {16'b0, memory_addr}, 32'd0);
    checkOutput("t6.hash", best_hash, 32'hFFFF_FFFF);
    checkOutput("t6.nonce", {24'b0, best_nonce}, 32'd0);
    checkOutput("t6.found", {31'b0, found}, 32'd0);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6.no_write0", mem[16'h0400], 32'h1234_5678);
    checkOutput("t6.no_write1", mem[16'h0401], 32'h1234_5678);
    checkOutput("t6.idle_done", {31'b0, done}, 32'd1);
    applyStimulus("t6r", 16'h0100, 16'h0400, 32'd5, 1'b1, 8'd15, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
